// File: rtl/eth_rx_mac_framer_if.sv
// ---------------------------------------------------------------------------
// eth_rx_mac_framer_if
//   Bundles the GMII receive inputs and the payload stream outputs of the
//   receive framer.
//   master : the framer (samples gmii_*, drives the payload stream and pulses)
//   slave  : the environment (drives gmii_*, consumes the payload stream)
//   Signals:
//     gmii_rxd[7:0], gmii_rx_dv, gmii_rx_er : PHY receive byte, valid, error
//     data_out[7:0], valid_out, last_out     : payload byte stream
//     error_out                              : frame bad, only with last_out
//     frame_good, frame_bad                  : one-cycle end-of-frame status
// ---------------------------------------------------------------------------
interface eth_rx_mac_framer_if;
  logic [7:0] gmii_rxd;
  logic       gmii_rx_dv;
  logic       gmii_rx_er;
  logic [7:0] data_out;
  logic       valid_out;
  logic       last_out;
  logic       error_out;
  logic       frame_good;
  logic       frame_bad;

  modport master (
    input  gmii_rxd, gmii_rx_dv, gmii_rx_er,
    output data_out, valid_out, last_out, error_out, frame_good, frame_bad
  );

  modport slave (
    output gmii_rxd, gmii_rx_dv, gmii_rx_er,
    input  data_out, valid_out, last_out, error_out, frame_good, frame_bad
  );
endinterface

// File: rtl/eth_rx_mac_framer.sv
// ---------------------------------------------------------------------------
// eth_rx_mac_framer
//   GMII receive framer. Locks onto preamble/SFD, strips preamble, SFD and
//   FCS, checks CRC-32, frame length and PHY error, and streams the payload
//   one byte per clock with no backpressure.
//   Ports:
//     clk : single clock, GMII inputs synchronous to it
//     rst : synchronous active-high reset
//     rx  : eth_rx_mac_framer_if.master (GMII in, payload stream + status out)
//   Parameters:
//     MIN_LEN / MAX_LEN : legal frame length range, DA..FCS inclusive
// ---------------------------------------------------------------------------
module eth_rx_mac_framer #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic                 clk,
  input  logic                 rst,
  eth_rx_mac_framer_if.master  rx
);

  localparam int          DEPTH       = 5;
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  // Running CRC register value after a frame and its own FCS have been
  // folded in (no final inversion applied).
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [15:0] MIN_LEN_W   = 16'(MIN_LEN);
  localparam logic [15:0] MAX_LEN_W   = 16'(MAX_LEN);
  localparam logic [15:0] LINE_FULL_W = 16'(DEPTH);

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    PREAMBLE,
    DATA
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  sr_reg   [DEPTH];
  logic [7:0]  sr_next  [DEPTH];
  logic [7:0]  sr_shift [DEPTH];
  logic [31:0] crc_reg, crc_next, crc_upd;
  logic [15:0] len_reg, len_next, len_inc;
  logic        err_flag_reg, err_flag_next;
  logic [7:0]  data_out_reg, data_out_next;
  logic        valid_out_reg, valid_out_next;
  logic        last_out_reg, last_out_next;
  logic        error_out_reg, error_out_next;
  logic        frame_good_reg, frame_good_next;
  logic        frame_bad_reg, frame_bad_next;
  logic        line_full;
  logic        bad_calc;

  // Bit-serial reflected CRC-32 over one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                             input logic [7:0]  d);
    logic [31:0] c;
    c = crc_in;
    for (int b = 0; b < 8; b++) begin
      if (c[0] ^ d[b]) c = (c >> 1) ^ CRC_POLY;
      else             c = c >> 1;
    end
    return c;
  endfunction

  // Delay line: newest byte enters at index 0. The four youngest bytes are
  // always the candidate FCS, so only bytes older than that are released.
  assign sr_shift[0] = rx.gmii_rxd;
  genvar gi;
  generate
    for (gi = 1; gi < DEPTH; gi++) begin : g_shift
      assign sr_shift[gi] = sr_reg[gi-1];
    end
  endgenerate

  assign crc_upd   = crc32_byte(crc_reg, rx.gmii_rxd);
  assign len_inc   = (len_reg == 16'hFFFF) ? len_reg : len_reg + 16'd1;
  assign line_full = (len_reg >= LINE_FULL_W);
  // Runts (line never filled) are always bad.
  assign bad_calc  = (crc_reg != CRC_RESIDUE) | err_flag_reg |
                     (len_reg < MIN_LEN_W) | (len_reg > MAX_LEN_W) | ~line_full;

  always_comb begin
    state_next      = state_reg;
    for (int i = 0; i < DEPTH; i++) sr_next[i] = sr_reg[i];
    crc_next        = crc_reg;
    len_next        = len_reg;
    err_flag_next   = err_flag_reg;
    data_out_next   = data_out_reg;
    valid_out_next  = 1'b0;
    last_out_next   = 1'b0;
    error_out_next  = 1'b0;
    frame_good_next = 1'b0;
    frame_bad_next  = 1'b0;

    case (state_reg)
      // Wait for a gap so we never lock onto the middle of a frame.
      WAIT_IDLE: begin
        if (!rx.gmii_rx_dv) state_next = IDLE;
      end

      IDLE: begin
        if (rx.gmii_rx_dv)
          state_next = (rx.gmii_rxd == 8'h55) ? PREAMBLE : WAIT_IDLE;
      end

      PREAMBLE: begin
        if (!rx.gmii_rx_dv) begin
          state_next = IDLE;
        end else if (rx.gmii_rx_er) begin
          state_next = WAIT_IDLE;
        end else if (rx.gmii_rxd == 8'h55) begin
          state_next = PREAMBLE;
        end else if (rx.gmii_rxd == 8'hD5) begin
          state_next    = DATA;
          crc_next      = CRC_INIT;
          len_next      = 16'd0;
          err_flag_next = 1'b0;
        end else begin
          state_next = WAIT_IDLE;
        end
      end

      DATA: begin
        if (rx.gmii_rx_dv) begin
          for (int i = 0; i < DEPTH; i++) sr_next[i] = sr_shift[i];
          crc_next      = crc_upd;
          len_next      = len_inc;
          err_flag_next = err_flag_reg | rx.gmii_rx_er;
          if (line_full) begin
            data_out_next  = sr_reg[DEPTH-1];
            valid_out_next = 1'b1;
          end
        end else begin
          // End of frame: oldest byte is the last payload byte, the rest is FCS.
          state_next = IDLE;
          if (line_full) begin
            data_out_next  = sr_reg[DEPTH-1];
            valid_out_next = 1'b1;
            last_out_next  = 1'b1;
            error_out_next = bad_calc;
          end
          frame_good_next = ~bad_calc;
          frame_bad_next  = bad_calc;
        end
      end

      default: state_next = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= WAIT_IDLE;
      for (int i = 0; i < DEPTH; i++) sr_reg[i] <= 8'd0;
      crc_reg        <= CRC_INIT;
      len_reg        <= 16'd0;
      err_flag_reg   <= 1'b0;
      data_out_reg   <= 8'd0;
      valid_out_reg  <= 1'b0;
      last_out_reg   <= 1'b0;
      error_out_reg  <= 1'b0;
      frame_good_reg <= 1'b0;
      frame_bad_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      for (int i = 0; i < DEPTH; i++) sr_reg[i] <= sr_next[i];
      crc_reg        <= crc_next;
      len_reg        <= len_next;
      err_flag_reg   <= err_flag_next;
      data_out_reg   <= data_out_next;
      valid_out_reg  <= valid_out_next;
      last_out_reg   <= last_out_next;
      error_out_reg  <= error_out_next;
      frame_good_reg <= frame_good_next;
      frame_bad_reg  <= frame_bad_next;
    end
  end

  assign rx.data_out   = data_out_reg;
  assign rx.valid_out  = valid_out_reg;
  assign rx.last_out   = last_out_reg;
  assign rx.error_out  = error_out_reg;
  assign rx.frame_good = frame_good_reg;
  assign rx.frame_bad  = frame_bad_reg;

endmodule
